// File: rtl/mux3_rr_pkg.sv
// Shared types, constants and the round-robin winner function for mux3_rr_sched.
package mux3_rr_pkg;

  localparam int         NREQ     = 3;
  localparam logic [1:0] SEL_NONE = 2'b11;

  typedef enum logic {IDLE, BUSY} state_e;

  // First requester at or after ptr+1, wrapping; ptr itself is checked last.
  function automatic logic [1:0] next_rr(input logic [1:0] ptr, input logic [NREQ-1:0] req);
    logic [1:0] w;
    logic       found;
    int         idx;
    w     = ptr;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        w     = 2'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational rotating-priority pick over three requesters.
module rr_pick3
  import mux3_rr_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      ptr,
  output logic [1:0]      win,
  output logic            vld
);

  assign vld = |req;
  assign win = next_rr(ptr, req);

endmodule

// File: rtl/mux3_rr_sched.sv
// Round-robin owner of the 3:1 select mux with registered output beat.
// Optional per-grant beat limit enabled by MUX3_RR_SCHED_TIMEOUT_EN.
module mux3_rr_sched
  import mux3_rr_pkg::*;
#(
  parameter int DW       = 1,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    last,
  input  logic [NREQ*DW-1:0] din,
  output logic [NREQ-1:0]    gnt,
  output logic [1:0]         sel,
  output logic [DW-1:0]      dout,
  output logic               dout_vld
`ifdef MUX3_RR_SCHED_TIMEOUT_EN
  ,
  output logic               timeout_pulse
`endif
);

  logic [NREQ-1:0][DW-1:0] lane;
  for (genvar g = 0; g < NREQ; g++) begin : g_lane
    assign lane[g] = din[g*DW +: DW];
  end

  state_e          state_q, state_d;
  logic [1:0]      owner_q, owner_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_d;
  logic [1:0]      sel_d;
  logic [DW-1:0]   dout_d;
  logic            vld_d;
  logic            rel;
  logic [1:0]      win;
  logic            win_vld;

  rr_pick3 u_pick (
    .req (req),
    .ptr (ptr_q),
    .win (win),
    .vld (win_vld)
  );

`ifdef MUX3_RR_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_d;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt;
    sel_d   = sel;
    dout_d  = dout;
    vld_d   = 1'b0;
    rel     = 1'b0;
`ifdef MUX3_RR_SCHED_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = BUSY;
          owner_d = win;
          gnt_d   = NREQ'(1) << win;
          sel_d   = win;
`ifdef MUX3_RR_SCHED_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        if (req[owner_q]) begin
          dout_d = lane[owner_q];
          vld_d  = 1'b1;
`ifdef MUX3_RR_SCHED_TIMEOUT_EN
          cnt_d  = cnt_q + 1'b1;
`endif
          if (last[owner_q]) rel = 1'b1;
`ifdef MUX3_RR_SCHED_TIMEOUT_EN
          // This beat is the MAX_HOLD-th of the grant.
          else if (cnt_q == CW'(MAX_HOLD - 1)) begin
            rel  = 1'b1;
            to_d = 1'b1;
          end
`endif
        end else begin
          rel = 1'b1;  // owner dropped req: abort without a beat
        end
      end
      default: state_d = IDLE;
    endcase
    if (rel) begin
      state_d = IDLE;
      gnt_d   = '0;
      sel_d   = SEL_NONE;
      ptr_d   = owner_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= 2'd2;
      gnt      <= '0;
      sel      <= SEL_NONE;
      dout     <= '0;
      dout_vld <= 1'b0;
`ifdef MUX3_RR_SCHED_TIMEOUT_EN
      cnt_q         <= '0;
      timeout_pulse <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      gnt      <= gnt_d;
      sel      <= sel_d;
      dout     <= dout_d;
      dout_vld <= vld_d;
`ifdef MUX3_RR_SCHED_TIMEOUT_EN
      cnt_q         <= cnt_d;
      timeout_pulse <= to_d;
`endif
    end
  end

endmodule

// File: doc/mux3_rr_sched.md
Name: mux3_rr_sched

Overview:
- Round-robin scheduler that shares the 3:1 select mux between three requesters.
- Each requester raises req, streams beats on its din lane while granted, and marks its final beat with last.
- The block drives the mux select, a one-hot grant, and a registered output beat with a valid flag.
- Sits in front of the 3:1 mux datapath, which it now owns.

Parameters:
- DW, 1, data width of each mux input lane and of dout.
- MAX_HOLD, 8, maximum beats per grant; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req  in  3  per-requester request; bit i belongs to requester i.
- last  in  3  per-requester final-beat marker; qualified by req[i] and gnt[i].
- din  in  3*DW  lanes: din[DW-1:0] is requester 0, din[2*DW-1:DW] is requester 1, din[3*DW-1:2*DW] is requester 2.
- gnt  out  3  one-hot grant, registered.
- sel  out  2  mux select; 2'b11 means no lane selected.
- dout  out  DW  registered selected beat.
- dout_vld  out  1  dout holds a beat accepted on the previous edge.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, gnt=3'b000, sel=2'b11, dout=0, dout_vld=0, ptr=2, so requester 0 wins first.
  - Reset mid-grant aborts the transfer with no further dout_vld.
- States: IDLE and BUSY, each with an owner index.
- IDLE:
  - If req is nonzero, pick the first set bit searching (ptr+1) mod 3, (ptr+2) mod 3, ptr.
  - Next edge: gnt = one-hot(owner), sel = owner, state = BUSY.
  - If req is zero, stay IDLE with sel=2'b11.
- BUSY, beat accepted on a clock edge when req[owner]=1:
  - dout <= din lane[owner], dout_vld <= 1.
  - If req[owner]=0, dout_vld <= 0 and dout holds its value.
- Release conditions, each taking effect on the same edge:
  - Accepted beat with last[owner]=1: normal release.
  - req[owner]=0: abort; no beat is emitted.
- On release:
  - state <= IDLE, gnt <= 0, sel <= 2'b11, ptr <= owner.
  - There is always a one-cycle bubble before the next grant.
- Latency:
  - req rises in cycle 0 with the block idle: gnt in cycle 1.
  - First beat is sampled at the end of cycle 1; dout_vld is seen in cycle 2.
  - Single-beat transfer (last high with the first beat): gnt is high for exactly one cycle.
- Other rules:
  - req and last on non-owners are ignored while BUSY; no preemption.
  - last without req is ignored.
  - gnt is always one-hot or zero; sel==owner whenever gnt!=0.
  - sel is never 2'b11 while BUSY.
- Fairness: with all three requesting continuously using single-beat transfers, grants cycle 0,1,2,0,... with one grant every 2 cycles.

Optional Feature:
- Macro: MUX3_RR_SCHED_TIMEOUT_EN.
- Defined:
  - A beat counter clears on grant and increments per accepted beat.
  - When the counter reaches MAX_HOLD without last, the grant is force-released on the edge that accepts the MAX_HOLD-th beat.
  - Release follows the normal release rules.
  - Adds output timeout_pulse (1 bit), high for one cycle after a forced release; reset value 0.
- Undefined:
  - No counter and no timeout_pulse port.
  - A grant is held indefinitely until last or req drop.

Decomposition:
- Package mux3_rr_pkg holds:
  - state enum (IDLE, BUSY);
  - constant SEL_NONE = 2'b11;
  - constant NREQ = 3;
  - function next_rr(ptr, req) returning the winner index.
- One sub-module, rr_pick3: combinational priority rotate (req, ptr) -> winner and valid.
- The scheduler FSM, output registers and mux stay in the top module.

Test Plan:
- Reset:
  - Stimulus: hold rst_n=0 for 2 cycles with req=3'b111.
  - Required: gnt=0, sel=2'b11, dout_vld=0 throughout.
  - After release, the first grant is gnt=3'b001 in the next cycle.
- Single beat:
  - Stimulus: DW=1, din={1,0,1}, req=3'b010 and last=3'b010 held.
  - Required: gnt=3'b010, sel=2'b01 in cycle 1; dout=0, dout_vld=1 in cycle 2; gnt=0 in cycle 2.
- Round-robin:
  - Stimulus: req=3'b111 and last=3'b111 held for 12 cycles.
  - Required: gnt sequence 001,000,010,000,100,000,001 with sel tracking 0,3,1,3,2,3,0.
- Burst and abort:
  - Stimulus: requester 2 granted, sends 3 beats with last on the third.
  - Required: dout_vld high for 3 cycles, then release.
  - Repeat with req[2] dropped after 1 beat: release with no further dout_vld.
- Non-owner ignore:
  - Stimulus: requester 0 mid-burst while requester 1 toggles req and last.
  - Required: gnt stays 3'b001 until last[0]; next grant goes to requester 1.
- Timeout (macro defined, MAX_HOLD=4):
  - Stimulus: requester 0 streams without last.
  - Required: exactly 4 dout_vld cycles, gnt drops, timeout_pulse=1 for one cycle.
